muldiv_iter: RTL and testbench

Parametrised iterative multiply/divide unit for the EX stage of the 5-stage core. It replaces the single-cycle 64-bit product path that feeds the HI/LO register file.
- Supports signed/unsigned MULT and DIV at configurable operand width.
- Uses a start/busy/done handshake and a flush input for exception/eret cancellation.
- Stall logic holds the EX stage while busy=1.

---
 rtl/muldiv_iter.sv | 143 ++++++++++++++
 tb/tb_muldiv_iter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// Iterative signed/unsigned multiply/divide unit: one bit per cycle, start/busy/done handshake.
// Optional define MULDIV_DIVZERO_FAST_EN: divide-by-zero bypasses the iteration phase.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  typedef struct packed {
    logic             div;
    logic             bz;
    logic             neg;
    logic             negr;
    logic [WIDTH-1:0] a;
  } ctx_t;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  ctx_t               ctx_q, ctx_d;

  logic               sgn_op, sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] mul_step, div_step;

  assign sgn_op = ~op[0];
  assign sa     = sgn_op & a[WIDTH-1];
  assign sb     = sgn_op & b[WIDTH-1];
  assign mag_a  = sa ? -a : a;
  assign mag_b  = sb ? -b : b;

  // Multiply: p = {partial, multiplier}; add multiplicand into the upper half, shift right.
  assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
  assign mul_step = {mul_sum, p_q[WIDTH-1:1]};

  // Restoring divide: p = {remainder, dividend/quotient}; shift left, trial-subtract divisor.
  assign div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, m_q};
  assign div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, m_q}) : div_shift[WIDTH-1:0];
  assign div_step  = {div_rem, p_q[WIDTH-2:0], div_ge};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    m_d     = m_q;
    ctx_d   = ctx_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            ctx_d.div  = op[1];
            ctx_d.bz   = (b == '0);
            ctx_d.neg  = sa ^ sb;
            ctx_d.negr = sa;
            ctx_d.a    = a;
            p_d        = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
            m_d        = op[1] ? mag_b : mag_a;
            cnt_d      = CW'(WIDTH - 1);
            state_d    = CALC;
`ifdef MULDIV_DIVZERO_FAST_EN
            if (op[1] && (b == '0)) state_d = FIX;
`endif
          end
        end
        CALC: begin
          p_d = ctx_q.div ? div_step : mul_step;
          if (cnt_q == '0) state_d = FIX;
          else             cnt_d   = cnt_q - 1'b1;
        end
        FIX: begin
          if (!ctx_q.div) begin
            {hi_d, lo_d} = ctx_q.neg ? -p_q : p_q;
          end else if (ctx_q.bz) begin
            hi_d = ctx_q.a;
            lo_d = '1;
          end else begin
            lo_d = ctx_q.neg  ? -p_q[WIDTH-1:0]       : p_q[WIDTH-1:0];
            hi_d = ctx_q.negr ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      m_q     <= '0;
      ctx_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      m_q     <= m_d;
      ctx_q   <= ctx_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter (WIDTH=32): directed vectors, random ops vs an arithmetic model,
// flush, back-to-back and mid-operation reset.
module tb_muldiv_iter;

  localparam int W = 32;
  localparam int LAT = W + 2;
`ifdef MULDIV_DIVZERO_FAST_EN
  localparam int LAT_DZ = 2;
`else
  localparam int LAT_DZ = W + 2;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] prev_hi = '0;
  logic [W-1:0] prev_lo = '0;

  muldiv_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit / integer arithmetic on the architectural definition.
  function automatic logic [2*W-1:0] model(input logic [1:0] mop, input logic [W-1:0] ma,
                                           input logic [W-1:0] mb);
    longint sp;
    logic [2*W-1:0] up;
    int sa, sb;
    sa = ma;
    sb = mb;
    case (mop)
      2'b00: begin sp = longint'(sa) * longint'(sb); return sp; end
      2'b01: begin up = {32'b0, ma} * {32'b0, mb}; return up; end
      2'b10: begin
        if (mb == 0) return {ma, 32'hFFFF_FFFF};
        if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {W'(sa % sb), W'(sa / sb)};
      end
      default: begin
        if (mb == 0) return {ma, 32'hFFFF_FFFF};
        return {ma % mb, ma / mb};
      end
    endcase
  endfunction

  // Drives start for one cycle from a negedge; returns at the negedge of cycle 1.
  task automatic issue(input logic [1:0] iop, input logic [W-1:0] ia, input logic [W-1:0] ib);
    op = iop; a = ia; b = ib; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at cycle 1; waits for done (bounded), leaves the bench at the done-cycle negedge.
  task automatic wait_done(input string name, input int exp_lat,
                           input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int cyc;
    bit busy_bad;
    busy_bad = 0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy !== 1'b1) busy_bad = 1;
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (cyc != exp_lat) begin
      fails++; $display("FAIL %s latency: got %0d expected %0d", name, cyc, exp_lat);
    end
    tests++;
    if (busy_bad || busy !== 1'b0) begin
      fails++; $display("FAIL %s busy: dropped early=%0d busy_at_done=%b expected 0", name, busy_bad, busy);
    end
    tests++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      fails++; $display("FAIL %s result: hi=%h lo=%h expected hi=%h lo=%h", name, hi, lo, exp_hi, exp_lo);
    end
    prev_hi = exp_hi;
    prev_lo = exp_lo;
  endtask

  task automatic pulse_ends(input string name);
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || hi !== prev_hi || lo !== prev_lo) begin
      fails++; $display("FAIL %s hold: done=%b hi=%h lo=%h expected done=0 hi=%h lo=%h",
                        name, done, hi, lo, prev_hi, prev_lo);
    end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
      fails++; $display("FAIL reset: busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, hi, lo;
    int           lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[6];
    v[0] = '{2'b00, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB, LAT};
    v[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, LAT};
    v[2] = '{2'b11, 32'd100,       32'd7,          32'd2,         32'd14,        LAT};
    v[3] = '{2'b10, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT};
    v[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0,         32'h8000_0000, LAT};
    v[5] = '{2'b11, 32'd5,         32'd0,          32'd5,         32'hFFFF_FFFF, LAT_DZ};
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b);
      wait_done($sformatf("directed%0d", i), v[i].lat, v[i].hi, v[i].lo);
      pulse_ends($sformatf("directed%0d", i));
    end
  endtask

  task automatic test_random();
    logic [1:0]     rop;
    logic [W-1:0]   ra, rb;
    logic [2*W-1:0] exp;
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = W'($urandom_range(1, 9));
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      exp = model(rop, ra, rb);
      issue(rop, ra, rb);
      wait_done($sformatf("random%0d op=%0d", i, rop),
                (rop[1] && rb == 0) ? LAT_DZ : LAT, exp[2*W-1:W], exp[W-1:0]);
      pulse_ends($sformatf("random%0d", i));
    end
  endtask

  task automatic test_flush();
    bit seen;
    issue(2'b01, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL flush busy: got %b expected 0", busy);
    end
    seen = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    tests++;
    if (seen || hi !== prev_hi || lo !== prev_lo) begin
      fails++; $display("FAIL flush result: done_seen=%0d hi=%h lo=%h expected no done hi=%h lo=%h",
                        seen, hi, lo, prev_hi, prev_lo);
    end
    flush = 1'b1;
    issue(2'b00, 32'd5, 32'd6);
    flush = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL start_with_flush busy: got %b expected 0", busy);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    issue(2'b01, 32'd1234, 32'd5678);
    repeat (4) @(negedge clk);
    issue(2'b01, 32'd99, 32'd99);
    wait_done("b2b_first", LAT - 5, 32'd0, 32'd7006652);
    issue(2'b11, 32'd1000, 32'd33);
    wait_done("b2b_second", LAT, 32'd10, 32'd30);
    pulse_ends("b2b_second");
  endtask

  task automatic test_reset_mid_op();
    issue(2'b10, 32'hFFFF_0000, 32'd37);
    repeat (14) @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
      fails++; $display("FAIL mid_reset: busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
    end
    prev_hi = '0;
    prev_lo = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(2'b01, 32'd2, 32'd3);
    wait_done("after_reset", LAT, 32'd0, 32'd6);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
